// File: rtl/dataslot_read_sequencer.sv
// Dataslot read sequencer: splits one load into chunked read requests towards the
// dataslot read issuer. It tracks each request's completion, handles timeouts and
// aborts, and reports done or error with an error code.
module dataslot_read_sequencer #(
  parameter logic [31:0] CHUNK_BYTES    = 32'h0001_0000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] slot_id_i,
  input  logic [31:0] slot_offset_i,
  input  logic [31:0] bridge_address_i,
  input  logic [31:0] total_length_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  error_code_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic [15:0] rd_slot_id_o,
  output logic [31:0] rd_offset_o,
  output logic [31:0] rd_address_o,
  output logic [31:0] rd_length_o,
  input  logic        rd_done_i,
  input  logic [1:0]  rd_status_i
);

  localparam logic [2:0] CodeNone    = 3'd0;
  localparam logic [2:0] CodeRange   = 3'd1;
  localparam logic [2:0] CodeStatus  = 3'd2;
  localparam logic [2:0] CodeTimeout = 3'd3;
  localparam logic [2:0] CodeAbort   = 3'd4;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  state_e      state_q, state_d;
  logic [15:0] slot_q, slot_d;
  logic [31:0] off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [23:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        fin_err_q, fin_err_d;
  logic [2:0]  code_q, code_d;

  logic [31:0] chunk_len;
  logic [32:0] off_sum;
  logic [32:0] addr_sum;
  logic        range_err;
  logic        timeout_hit;

  assign chunk_len = (rem_q < CHUNK_BYTES) ? rem_q : CHUNK_BYTES;
  assign off_sum   = {1'b0, slot_offset_i} + {1'b0, total_length_i};
  assign addr_sum  = {1'b0, bridge_address_i} + {1'b0, total_length_i};
  assign range_err = off_sum[32] | addr_sum[32];

  // cnt_q counts cycles since the handshake (1 in the first WAIT cycle), so the error
  // pulse lands exactly TIMEOUT_CYCLES cycles after the handshake cycle.
  assign timeout_hit = ({1'b0, cnt_q} + 25'd1) >= {1'b0, TIMEOUT_CYCLES};

  // Next-state logic: load capture, request issue, completion tracking and finish.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    off_d     = off_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    fin_err_d = fin_err_q;
    code_d    = code_q;

    case (state_q)
      StIdle: begin
        // A concurrent abort is deliberately dropped: start wins in IDLE.
        if (start_i) begin
          slot_d    = slot_id_i;
          off_d     = slot_offset_i;
          addr_d    = bridge_address_i;
          rem_d     = total_length_i;
          cnt_d     = '0;
          abort_d   = 1'b0;
          fin_err_d = 1'b0;
          code_d    = CodeNone;
          if (total_length_i == 32'd0) begin
            state_d = StFinish;
          end else if (range_err) begin
            state_d   = StFinish;
            fin_err_d = 1'b1;
            code_d    = CodeRange;
          end else begin
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        if (abort_i) abort_d = 1'b1;
        if (rd_ready_i) begin
          rem_d   = rem_q - chunk_len;
          off_d   = off_q + chunk_len;
          addr_d  = addr_q + chunk_len;
          cnt_d   = 24'd1;
          state_d = StWait;
        end
      end

      StWait: begin
        if (abort_i) abort_d = 1'b1;
        cnt_d = cnt_q + 24'd1;
        // Completion is checked first so a done coinciding with expiry still counts.
        if (rd_done_i) begin
          if (rd_status_i != 2'd0) begin
            state_d   = StFinish;
            fin_err_d = 1'b1;
            code_d    = CodeStatus;
          end else if (abort_q || abort_i) begin
            state_d   = StFinish;
            fin_err_d = 1'b1;
            code_d    = CodeAbort;
          end else if (rem_q != 32'd0) begin
            state_d = StIssue;
          end else begin
            state_d = StFinish;
          end
        end else if (timeout_hit) begin
          state_d   = StFinish;
          fin_err_d = 1'b1;
          code_d    = CodeTimeout;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      off_q     <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      fin_err_q <= 1'b0;
      code_q    <= CodeNone;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      fin_err_q <= fin_err_d;
      code_q    <= code_d;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free and stable.
  always_comb begin
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StFinish) && !fin_err_q;
    error_o      = (state_q == StFinish) && fin_err_q;
    error_code_o = code_q;
    rd_valid_o   = (state_q == StIssue);
    rd_slot_id_o = slot_q;
    rd_offset_o  = off_q;
    rd_address_o = addr_q;
    rd_length_o  = chunk_len;
  end

endmodule

// File: tb/tb_dataslot_read_sequencer.sv
// Self-checking bench for dataslot_read_sequencer: directed corner cases plus
// randomized loads checked against a transaction-level model of the chunking rules.
module tb_dataslot_read_sequencer;

  localparam logic [31:0] CHUNK   = 32'h0001_0000;
  localparam int          TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] slot_id;
  logic [31:0] slot_offset, bridge_address, total_length;
  logic        busy, done, error;
  logic [2:0]  error_code;
  logic        rd_valid, rd_ready;
  logic [15:0] rd_slot_id;
  logic [31:0] rd_offset, rd_address, rd_length;
  logic        rd_done;
  logic [1:0]  rd_status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dataslot_read_sequencer #(
    .CHUNK_BYTES   (CHUNK),
    .TIMEOUT_CYCLES(24'(TIMEOUT))
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .abort_i         (abort),
    .slot_id_i       (slot_id),
    .slot_offset_i   (slot_offset),
    .bridge_address_i(bridge_address),
    .total_length_i  (total_length),
    .busy_o          (busy),
    .done_o          (done),
    .error_o         (error),
    .error_code_o    (error_code),
    .rd_valid_o      (rd_valid),
    .rd_ready_i      (rd_ready),
    .rd_slot_id_o    (rd_slot_id),
    .rd_offset_o     (rd_offset),
    .rd_address_o    (rd_address),
    .rd_length_o     (rd_length),
    .rd_done_i       (rd_done),
    .rd_status_i     (rd_status)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load-field inputs matter only on an accepted start; keep them noisy otherwise.
  task automatic scramble();
    slot_id        = 16'($urandom);
    slot_offset    = $urandom;
    bridge_address = $urandom;
    total_length   = $urandom;
  endtask

  // Checks the FINISH cycle, then the return to IDLE.
  task automatic expect_finish(input bit is_err, input logic [2:0] code);
    check_eq("fin_done", done, !is_err);
    check_eq("fin_error", error, is_err);
    check_eq("fin_code", error_code, code);
    check_eq("fin_busy", busy, 1'b1);
    check_eq("fin_rd_valid", rd_valid, 1'b0);
    tick();
    rd_done = 1'b0;
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_pulses", {done, error}, 2'b00);
    check_eq("idle_code_hold", error_code, code);
    tick();
    check_eq("idle_no_request", rd_valid, 1'b0);
  endtask

  // One complete load. Indices select which request fails, times out or is aborted
  // (-1 = never). done_dly/rdy_fixed < 0 pick random delays.
  task automatic run_load(input logic [15:0] slot, input logic [31:0] off,
                          input logic [31:0] addr, input logic [31:0] len,
                          input int fail_idx, input int to_idx, input int abort_idx,
                          input bit abort_in_issue, input bit abort_at_start,
                          input int done_dly, input int rdy_fixed);
    logic [31:0] q_len[$];
    logic [31:0] q_off[$];
    logic [31:0] q_addr[$];
    logic [31:0] rem, o, a, l;
    logic [32:0] so, sa;
    logic [1:0]  st;
    bit          aborted;
    int          rdy_dly, dly;

    rem = len; o = off; a = addr;
    while (rem != 0) begin
      l = (rem < CHUNK) ? rem : CHUNK;
      q_len.push_back(l); q_off.push_back(o); q_addr.push_back(a);
      rem -= l; o += l; a += l;
    end
    so = {1'b0, off} + {1'b0, len};
    sa = {1'b0, addr} + {1'b0, len};

    start = 1'b1; abort = abort_at_start;
    slot_id = slot; slot_offset = off; bridge_address = addr; total_length = len;
    tick();
    start = 1'b0; abort = 1'b0;
    scramble();

    if (len == 32'd0) begin
      expect_finish(1'b0, 3'd0);
      return;
    end
    if (so[32] || sa[32]) begin
      expect_finish(1'b1, 3'd1);
      return;
    end

    aborted = 1'b0;
    for (int i = 0; i < q_len.size(); i++) begin
      rdy_dly = (rdy_fixed >= 0) ? rdy_fixed : $urandom_range(0, 3);
      if (i == abort_idx && abort_in_issue) begin
        abort = 1'b1; aborted = 1'b1;
      end
      for (int d = 0; d <= rdy_dly; d++) begin
        check_eq("req_valid", rd_valid, 1'b1);
        check_eq("req_slot", rd_slot_id, slot);
        check_eq("req_offset", rd_offset, q_off[i]);
        check_eq("req_address", rd_address, q_addr[i]);
        check_eq("req_length", rd_length, q_len[i]);
        rd_ready = (d == rdy_dly);
        start    = ($urandom_range(0, 3) == 0);
        rd_done  = ($urandom_range(0, 3) == 0);
        tick();
        abort = 1'b0; start = 1'b0; rd_done = 1'b0;
        scramble();
      end
      rd_ready = 1'b0;
      check_eq("wait_valid_low", rd_valid, 1'b0);
      check_eq("wait_busy", busy, 1'b1);
      if (i == abort_idx && !abort_in_issue) begin
        abort = 1'b1; aborted = 1'b1;
      end

      if (i == to_idx) begin
        for (int k = 0; k < TIMEOUT - 1; k++) begin
          check_eq("to_no_pulse", {done, error, rd_valid}, 3'b000);
          tick();
          abort = 1'b0;
        end
        rd_done = 1'b1; rd_status = 2'd0;
        expect_finish(1'b1, 3'd3);
        return;
      end

      dly = (done_dly >= 0) ? done_dly : $urandom_range(0, 5);
      for (int k = 0; k < dly; k++) begin
        check_eq("wait_no_pulse", {done, error, rd_valid}, 3'b000);
        tick();
        abort = 1'b0;
      end
      st = (i == fail_idx) ? 2'($urandom_range(1, 3)) : 2'd0;
      rd_done = 1'b1; rd_status = st;
      tick();
      rd_done = 1'b0; rd_status = 2'd0; abort = 1'b0;

      if (st != 2'd0) begin
        expect_finish(1'b1, 3'd2);
        return;
      end
      if (aborted) begin
        expect_finish(1'b1, 3'd4);
        return;
      end
    end
    expect_finish(1'b0, 3'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] len, off, addr;
    int          n, r, fi, ti, ai;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    rd_done = 1'b0; rd_status = 2'd0;
    scramble();
    tick(); tick();
    check_eq("reset_outputs", {busy, done, error, rd_valid}, 4'b0000);
    check_eq("reset_code", error_code, 3'd0);
    rst_n = 1'b1;
    tick();

    // Three-chunk load with the final chunk short.
    run_load(16'h00A5, 32'h0, 32'h1000_0000, 32'h0002_8000, -1, -1, -1, 0, 0, -1, 0);
    // Zero length, and range overflow on offset / address (including the exact 2^32 edge).
    run_load(16'h0001, 32'h0, 32'h0, 32'h0, -1, -1, -1, 0, 0, -1, -1);
    run_load(16'h0002, 32'hFFFF_FF00, 32'h0, 32'h200, -1, -1, -1, 0, 0, -1, -1);
    run_load(16'h0003, 32'hFFFF_FF00, 32'h0, 32'h100, -1, -1, -1, 0, 0, -1, -1);
    run_load(16'h0004, 32'hFFFF_FF00, 32'h0, 32'hFF, -1, -1, -1, 0, 0, -1, -1);
    run_load(16'h0005, 32'h0, 32'hFFFF_FFFF, 32'h1, -1, -1, -1, 0, 0, -1, -1);
    // Slot error on the second request with rd_ready held low for 5 cycles.
    run_load(16'h0006, 32'h40, 32'h2000_0000, 32'h0002_8000, 1, -1, -1, 0, 0, -1, 5);
    // Error code holds until the next start; reset clears it.
    tick(); tick();
    check_eq("code_hold", error_code, 3'd2);
    rst_n = 1'b0;
    #1;
    check_eq("reset_async_code", error_code, 3'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // Timeout, done coinciding with expiry, abort variants.
    run_load(16'h0007, 32'h0, 32'h0, 32'h0002_0000, -1, 0, -1, 0, 0, -1, -1);
    run_load(16'h0008, 32'h0, 32'h0, 32'h0001_0000, -1, -1, -1, 0, 0, TIMEOUT - 2, -1);
    run_load(16'h0009, 32'h0, 32'h0, 32'h0002_8000, -1, -1, 0, 0, 0, -1, -1);
    run_load(16'h000A, 32'h0, 32'h0, 32'h0002_8000, -1, -1, 0, 1, 0, -1, -1);
    run_load(16'h000B, 32'h0, 32'h0, 32'h0002_0000, -1, 0, 0, 0, 0, -1, -1);
    run_load(16'h000C, 32'h0, 32'h0, 32'h0002_0000, 0, -1, 0, 0, 0, -1, -1);
    run_load(16'h000D, 32'h0, 32'h0, 32'h0000_0010, -1, -1, -1, 0, 1, -1, -1);
    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("idle_abort", {busy, error}, 2'b00);

    // Reset mid-load abandons it and a late rd_done is ignored.
    start = 1'b1; slot_id = 16'h77; slot_offset = 0; bridge_address = 0;
    total_length = 32'h0002_0000;
    tick();
    start = 1'b0; rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midload_reset", {busy, done, error, rd_valid}, 4'b0000);
    tick();
    rst_n = 1'b1;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("post_reset_quiet", {busy, done, error, rd_valid}, 4'b0000);
      tick();
    end

    // Randomized loads.
    for (int it = 0; it < 40; it++) begin
      r    = $urandom_range(0, 9);
      off  = $urandom & 32'h7FFF_FFFF;
      addr = $urandom & 32'h7FFF_FFFF;
      len  = 32'($urandom_range(1, 32'h0003_0000));
      if (r == 0) len = 32'h0;
      if (r == 1) off = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFF);
      if (r == 2) addr = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFF);
      n  = int'((len + CHUNK - 1) / CHUNK);
      fi = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      ti = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      ai = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_load(16'($urandom), off, addr, len, fi, ti, ai, 1'($urandom_range(0, 1)), 1'b0, -1,
               -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dataslot_read_sequencer.md
DATASLOT_READ_SEQUENCER -- requirements
Module: dataslot_read_sequencer

Interface
REQ-001 SHALL have parameter CHUNK_BYTES, default 32'h0001_0000, max bytes per single read request; legal range 1 to 2^31.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd10_000_000, max cycles waiting for a request's completion.
REQ-003 SHALL use one clock; reset is asynchronous and active-low: clk  in  1  bridge clock, all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse; begin a load.
REQ-006 abort  in  1  one-cycle pulse; cancel the active load.
REQ-007 slot_id  in  16  dataslot to read; sampled on accepted start.
REQ-008 slot_offset  in  32  byte offset in slot; sampled on accepted start.
REQ-009 bridge_address  in  32  destination bridge address; sampled on accepted start.
REQ-010 total_length  in  32  bytes to load; sampled on accepted start.
REQ-011 busy  out  1  high from accepted start until the done/error pulse cycle inclusive.
REQ-012 done  out  1  one-cycle pulse on successful completion.
REQ-013 error  out  1  one-cycle pulse on failure.
REQ-014 error_code  out  3  0 none, 1 range overflow, 2 slot status error, 3 timeout, 4 aborted.
REQ-015 rd_valid / rd_ready  out / in  1 / 1  request handshake towards core_dataslot_read issuer.
REQ-016 rd_slot_id, rd_offset, rd_address, rd_length  out  16, 32, 32, 32  request fields.
REQ-017 rd_done  in  1  one-cycle completion pulse for the outstanding request.
REQ-018 rd_status  in  2  completion status valid with rd_done; 0 = OK, nonzero = failure.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, FINISH.
REQ-020 start SHALL be accepted only in IDLE; start while busy SHALL be ignored with no output change.
REQ-021 On accepted start with total_length = 0: no request issued, done pulses the next cycle, error_code = 0.
REQ-022 On accepted start, if slot_offset + total_length or bridge_address + total_length exceeds 2^32 (33-bit sum, carry set): no request, error pulses next cycle, error_code = 1.
REQ-023 Otherwise, rd_valid SHALL rise the cycle after start (ISSUE), error_code cleared to 0.
REQ-024 Each request: rd_length = min(CHUNK_BYTES, remaining); rd_offset/rd_address = running offset/address; rd_slot_id constant.
REQ-025 rd_valid and all rd_* fields SHALL remain stable until the cycle with rd_valid & rd_ready; rd_valid low the following cycle (WAIT).
REQ-026 On handshake: remaining -= rd_length, offset and address += rd_length; timeout counter cleared.
REQ-027 In WAIT, rd_done with rd_status = 0: if remaining > 0, next cycle ISSUE (rd_valid high); else done pulses next cycle.
REQ-028 In WAIT, rd_done with rd_status != 0: error pulses next cycle, error_code = 2; no further requests.
REQ-029 In WAIT, counter reaching TIMEOUT_CYCLES without rd_done: error pulses next cycle, error_code = 3; a late rd_done is ignored.
REQ-030 rd_done in the same cycle the timeout expires SHALL win (treated as completion).
REQ-031 rd_done outside WAIT SHALL be ignored.
REQ-032 abort in ISSUE or WAIT SHALL set abort_pending; the current request completes its handshake and rd_done (or timeout), then error pulses with error_code = 4 instead of issuing more or pulsing done; a slot error or timeout in that same request takes precedence (code 2/3).
REQ-033 abort in IDLE SHALL be ignored; abort and start in the same IDLE cycle: start accepted, abort ignored.
REQ-034 error_code SHALL hold its value until the next accepted start.
REQ-035 FINISH lasts one cycle (done or error pulse, busy high), then IDLE; start is accepted the cycle after FINISH.

Reset
REQ-036 reset_n low SHALL immediately force IDLE; busy, done, error, rd_valid = 0; error_code = 0; counters, remaining, abort_pending = 0.
REQ-037 Reset mid-load SHALL abandon the load with no done/error pulse; an rd_done arriving after reset release is ignored.

Verification
REQ-038 start, offset 0, addr 32'h1000_0000, length 32'h0002_8000, CHUNK 64K, rd_ready tied 1 -> three requests of lengths 10000h, 10000h, 8000h at addresses 1000_0000h, 1001_0000h, 1002_0000h; single done pulse.
REQ-039 start length 0 -> no rd_valid, done pulses one cycle after start, error_code 0.
REQ-040 slot_offset FFFF_FF00h, length 200h -> no request, error pulse, error_code 1.
REQ-041 second rd_done with rd_status 2 -> error pulse, error_code 2, no third request; rd_ready held low 5 cycles on a request -> fields stable throughout.
REQ-042 TIMEOUT_CYCLES = 16, rd_done withheld -> error pulse 16 cycles after handshake, code 3; abort during first WAIT then rd_done OK -> error code 4, no second request.
